// File: rtl/div_unit_32_pkg.sv
// rtl/div_unit_32_pkg.sv - shared constants and helpers for the restoring divider
package div_unit_32_pkg;
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_FIN  = 2'd2;

   localparam int DIV_LATENCY = 33;
   localparam logic [31:0] DIV0_QUOTIENT = 32'hFFFF_FFFF;

   function automatic logic [31:0] neg32(input logic [31:0] x);
      return ~x + 32'd1;
   endfunction
endpackage

// File: rtl/add_sub_32.sv
// rtl/add_sub_32.sv - 32-bit adder/subtractor; in subtract mode cout=1 means no borrow
module add_sub_32 (
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        sub,
   output logic [31:0] sum,
   output logic        cout
);
   logic [31:0] b_eff;

   assign b_eff        = sub ? ~b : b;
   assign {cout, sum}  = {1'b0, a} + {1'b0, b_eff} + {32'd0, sub};
endmodule

// File: rtl/div_unit_32.sv
// rtl/div_unit_32.sv - multi-cycle restoring DIV/DIVU, one quotient bit per clock
module div_unit_32
   import div_unit_32_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);
   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] r_q, r_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] dv_q, dv_d;
   logic             qneg_q, qneg_d;
   logic             rneg_q, rneg_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic             dbz_q, dbz_d;

   logic [WIDTH:0]   s;
   logic [WIDTH-1:0] trial;
   logic             cout;
   logic             take;

   assign s    = {r_q, q_q[WIDTH-1]};
   assign take = s[WIDTH] | cout;

   add_sub_32 u_trial_sub (
      .a    (s[WIDTH-1:0]),
      .b    (dv_q),
      .sub  (1'b1),
      .sum  (trial),
      .cout (cout)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      r_d     = r_q;
      q_d     = q_q;
      dv_d    = dv_q;
      qneg_d  = qneg_q;
      rneg_d  = rneg_q;
      quo_d   = quo_q;
      rem_d   = rem_q;
      dbz_d   = dbz_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               dbz_d = 1'b0;
               if (divisor == '0) begin
                  quo_d   = DIV0_QUOTIENT;
                  rem_d   = dividend;
                  dbz_d   = 1'b1;
                  state_d = ST_FIN;
               end else begin
                  q_d     = (is_signed && dividend[WIDTH-1]) ? neg32(dividend) : dividend;
                  dv_d    = (is_signed && divisor[WIDTH-1]) ? neg32(divisor) : divisor;
                  qneg_d  = is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                  rneg_d  = is_signed & dividend[WIDTH-1];
                  r_d     = '0;
                  cnt_d   = '0;
                  state_d = ST_RUN;
               end
            end
         end
         ST_RUN: begin
            r_d   = take ? trial : s[WIDTH-1:0];
            q_d   = {q_q[WIDTH-2:0], take};
            cnt_d = cnt_q + 1'b1;
            // Results are loaded on the last step so they are already valid in the done cycle.
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               quo_d   = qneg_q ? neg32(q_d) : q_d;
               rem_d   = rneg_q ? neg32(r_d) : r_d;
               state_d = ST_FIN;
            end
         end
         ST_FIN:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         r_q     <= '0;
         q_q     <= '0;
         dv_q    <= '0;
         qneg_q  <= 1'b0;
         rneg_q  <= 1'b0;
         quo_q   <= '0;
         rem_q   <= '0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         r_q     <= r_d;
         q_q     <= q_d;
         dv_q    <= dv_d;
         qneg_q  <= qneg_d;
         rneg_q  <= rneg_d;
         quo_q   <= quo_d;
         rem_q   <= rem_d;
         dbz_q   <= dbz_d;
      end
   end

   assign busy        = (state_q != ST_IDLE);
   assign done        = (state_q == ST_FIN);
   assign quotient    = quo_q;
   assign remainder   = rem_q;
   assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_div_unit_32.sv
// tb/tb_div_unit_32.sv - scoreboard bench for div_unit_32 against an arithmetic reference
module tb_div_unit_32;
   import div_unit_32_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        is_signed = 1'b0;
   logic [31:0] dividend = '0;
   logic [31:0] divisor = '0;
   logic        busy, done, div_by_zero;
   logic [31:0] quotient, remainder;

   div_unit_32 #(.WIDTH(32), .CNT_W(6)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .is_signed   (is_signed),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] q;
      logic [31:0] r;
      logic        dbz;
      int          due;
      string       name;
   } exp_t;

   exp_t sb[$];
   int   vectors = 0;
   int   miscompares = 0;

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endfunction

   // Reference: plain 64-bit arithmetic, which also absorbs the -2^31 / -1 overflow case.
   function automatic exp_t model(input bit s, input logic [31:0] a, input logic [31:0] b);
      exp_t e;
      longint sa, sd;
      longint unsigned ua, ud;
      e.dbz = 1'b0;
      if (b == 32'd0) begin
         e.q = 32'hFFFF_FFFF;
         e.r = a;
         e.dbz = 1'b1;
      end else if (s) begin
         sa = longint'($signed(a));
         sd = longint'($signed(b));
         e.q = 32'(sa / sd);
         e.r = 32'(sa % sd);
      end else begin
         ua = {32'd0, a};
         ud = {32'd0, b};
         e.q = 32'(ua / ud);
         e.r = 32'(ua % ud);
      end
      e.due = 0;
      e.name = "";
      return e;
   endfunction

   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         if (done) begin
            if (sb.size() == 0) begin
               chk("spurious_done", 32'(done), 32'd0);
            end else begin
               e = sb.pop_front();
               chk({e.name, ".quotient"}, quotient, e.q);
               chk({e.name, ".remainder"}, remainder, e.r);
               chk({e.name, ".div_by_zero"}, 32'(div_by_zero), 32'(e.dbz));
               chk({e.name, ".done_cycle"}, 32'(cyc), 32'(e.due));
               chk({e.name, ".busy_at_done"}, 32'(busy), 32'd1);
            end
         end else if (sb.size() > 0 && cyc > sb[0].due) begin
            e = sb.pop_front();
            chk({e.name, ".timeout_done"}, 32'(done), 32'd1);
         end
      end
   end

   task automatic wait_idle();
      int n = 0;
      while (busy || done) begin
         @(posedge clk); #1;
         n++;
         if (n > 100) begin
            chk("wait_idle_timeout", 32'(busy), 32'd0);
            break;
         end
      end
   endtask

   task automatic issue(input bit s, input logic [31:0] a, input logic [31:0] b,
                        input bit push, input string nm);
      exp_t e;
      wait_idle();
      start = 1'b1;
      is_signed = s;
      dividend = a;
      divisor = b;
      if (push) begin
         e = model(s, a, b);
         e.due = cyc + ((b == 32'd0) ? 1 : DIV_LATENCY);
         e.name = nm;
         sb.push_back(e);
      end
      @(posedge clk); #1;
      start = 1'b0;
      dividend = $urandom;
      divisor = $urandom;
      is_signed = $urandom_range(0, 1) != 0;
   endtask

   initial begin
      int n;
      bit s;
      logic [31:0] a, b;

      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("reset.busy", 32'(busy), 32'd0);
      chk("reset.done", 32'(done), 32'd0);
      chk("reset.quotient", quotient, 32'd0);
      chk("reset.remainder", remainder, 32'd0);
      chk("reset.div_by_zero", 32'(div_by_zero), 32'd0);
      @(posedge clk); #1;

      issue(1'b0, 32'd100, 32'd7, 1'b1, "divu_100_7");
      chk("busy_after_accept", 32'(busy), 32'd1);
      issue(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b1, "div_m7_2");
      issue(1'b0, 32'hFFFF_FFFF, 32'd1, 1'b1, "divu_max_1");
      issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "div_overflow");
      issue(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "divu_min_max");
      issue(1'b1, 32'd123, 32'd0, 1'b1, "div_by_zero");

      issue(1'b0, 32'd50, 32'd5, 1'b1, "after_div0");
      @(negedge clk);
      chk("next_start.dbz_cleared", 32'(div_by_zero), 32'd0);
      chk("next_start.quotient_held", quotient, 32'hFFFF_FFFF);
      chk("next_start.remainder_held", remainder, 32'd123);
      @(posedge clk); #1;

      issue(1'b0, 32'd1000, 32'd10, 1'b1, "ignored_start");
      repeat (9) @(posedge clk);
      #1;
      start = 1'b1;
      dividend = 32'd5;
      divisor = 32'd0;
      @(posedge clk); #1;
      start = 1'b0;

      issue(1'b0, 32'd12345, 32'd7, 1'b0, "aborted");
      repeat (18) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("mid_run_reset.busy", 32'(busy), 32'd0);
      chk("mid_run_reset.quotient", quotient, 32'd0);
      chk("mid_run_reset.remainder", remainder, 32'd0);
      chk("mid_run_reset.div_by_zero", 32'(div_by_zero), 32'd0);
      repeat (40) @(posedge clk);
      #1;

      for (int i = 0; i < 1500; i++) begin
         s = $urandom_range(0, 1) != 0;
         a = $urandom;
         case ($urandom_range(0, 7))
            0:       b = 32'd0;
            1:       b = 32'($urandom_range(1, 15));
            2:       b = 32'hFFFF_FFFF;
            3: begin a = 32'h8000_0000; b = $urandom; end
            4:       b = $urandom >> $urandom_range(0, 31);
            default: b = $urandom;
         endcase
         issue(s, a, b, 1'b1, "random");
      end

      n = 0;
      while (sb.size() > 0 && n < 100) begin
         @(posedge clk);
         n++;
      end
      if (sb.size() > 0) chk("drain_timeout", 32'(sb.size()), 32'd0);
      repeat (3) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
